ieee754_unpacker: RTL and testbench
===================================

IEEE754_UNPACKER -- requirements
Module: ieee754_unpacker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: in_data holds a word to unpack.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a word; high iff state IDLE.
REQ-005 SHALL have port in_data, input, 32 bits: IEEE-754 single (sign[31], exp[30:23], frac[22:0]).
REQ-006 SHALL have port out_valid, output, 1 bit: unpacked result available.
REQ-007 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-008 SHALL have port out_sign, output, 1 bit: copy of in_data[31], for all classes.
REQ-009 SHALL have port out_exp, output, 10 bits signed: unbiased exponent after normalisation.
REQ-010 SHALL have port out_mant, output, 24 bits: significand, hidden bit at [23].
REQ-011 SHALL have port out_class, output, 3 bits: ZERO=0, SUBNORMAL=1, NORMAL=2, INF=3, NAN=4.

Function
REQ-012 SHALL accept a word on the edge where in_valid and in_ready are both high; otherwise in_data is ignored.
REQ-013 SHALL implement FSM IDLE -> (DONE | NORM); NORM -> NORM while out_mant[23]=0; NORM -> DONE on the shift that sets mant[23]; DONE -> IDLE on out_valid and out_ready.
REQ-014 SHALL decode at accept (e = exp field, f = frac field): e=0,f=0 -> ZERO, exp 0, mant 0, goto DONE.
REQ-015 SHALL decode e in 1..254 -> NORMAL, exp = e-127, mant = {1,f}, goto DONE.
REQ-016 SHALL decode e=255,f=0 -> INF, and e=255,f!=0 -> NAN; both exp 128, mant {1,f}, goto DONE.
REQ-017 SHALL decode e=0,f!=0 -> SUBNORMAL, load exp -126, mant {0,f}, goto NORM.
REQ-018 SHALL in NORM shift mant left by one bit and decrement exp by one per cycle; this takes lz cycles, lz = leading zeros of {0,f} (1..23).
REQ-019 SHALL keep SUBNORMAL exponent in -127..-149 and all exponents inside the 10-bit signed range, with no wrap.
REQ-020 SHALL assert out_valid exactly in DONE: 1 cycle after accept for ZERO/NORMAL/INF/NAN, 1+lz cycles for SUBNORMAL.
REQ-021 SHALL hold out_sign/out_exp/out_mant/out_class stable while out_valid=1 and out_ready=0.
REQ-022 SHALL drop out_valid after the output handshake edge and raise in_ready in the next cycle; throughput is at most one word per 2 cycles, and in_valid held high during DONE is not accepted.
REQ-023 SHALL ignore out_ready outside DONE and in_valid outside IDLE.

Reset
REQ-024 SHALL on rst_n low force, immediately and asynchronously: state IDLE, out_valid 0, in_ready 1, out_sign 0, out_exp 0, out_mant 0, out_class ZERO.
REQ-025 SHALL abandon any word in NORM or DONE when reset is asserted mid-operation; no partial result is ever presented.

Structure
REQ-026 SHALL take the following from shared package ieee754_pkg: class enum, FSM state enum, EXP_W=8, FRAC_W=23, BIAS=127.
REQ-027 SHALL place the combinational field decode/classification in one sub-module, ieee754_classify; the FSM and shifter stay in ieee754_unpacker.

Verification
REQ-028 SHALL cover: 0x41F00000 (30.0) -> sign 0, exp 4, mant 0xF00000, NORMAL, out_valid 1 cycle after accept.
REQ-029 SHALL cover: 0x00000001 -> exp -149, mant 0x800000, SUBNORMAL, out_valid 24 cycles after accept.
REQ-030 SHALL cover: 0xFF800000 -> sign 1, INF, exp 128, mant 0x800000; and 0x7FC00000 -> NAN, mant 0xC00000; and 0x80000000 -> sign 1, ZERO, exp 0, mant 0.
REQ-031 SHALL cover: 0x41200000 (10.0) with out_ready low 5 cycles -> exp 3, mant 0xA00000 held stable, in_ready 0; after the handshake, in_ready 1 on the next cycle.
REQ-032 SHALL cover: 0x00000100 accepted (lz 15), rst_n low at cycle 5 of NORM -> out_valid 0 and in_ready 1 without waiting for a clock edge, and no result is emitted after release.

Source files
------------

// File: rtl/ieee754_pkg.sv
// Shared types and field widths for the IEEE-754 single unpacker.
// Class and FSM encodings used by the classifier and the top.
package ieee754_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;
  localparam int OEXP_W = 10;
  localparam int MANT_W = FRAC_W + 1;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SUB    = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ieee754_classify.sv
// Combinational field decode of an IEEE-754 single into class,
// initial exponent/significand and a flag for subnormal renormalisation.
module ieee754_classify
  import ieee754_pkg::*;
(
  input  logic [31:0]              word,
  output logic                     sign,
  output logic signed [OEXP_W-1:0] exp,
  output logic [MANT_W-1:0]        mant,
  output cls_e                     cls,
  output logic                     need_norm
);

  logic [EXP_W-1:0]  e;
  logic [FRAC_W-1:0] f;
  logic              e_zero;
  logic              e_ones;
  logic              f_zero;

  assign e      = word[30:23];
  assign f      = word[22:0];
  assign e_zero = (e == '0);
  assign e_ones = (e == '1);
  assign f_zero = (f == '0);

  always_comb begin
    sign      = word[31];
    exp       = '0;
    mant      = '0;
    cls       = CLS_ZERO;
    need_norm = 1'b0;
    unique case (1'b1)
      e_zero && f_zero: begin
        cls = CLS_ZERO;
      end
      e_zero && !f_zero: begin
        cls       = CLS_SUB;
        exp       = -10'sd126;
        mant      = {1'b0, f};
        need_norm = 1'b1;
      end
      e_ones: begin
        cls  = f_zero ? CLS_INF : CLS_NAN;
        exp  = 10'sd128;
        mant = {1'b1, f};
      end
      !e_zero && !e_ones: begin
        cls  = CLS_NORMAL;
        exp  = $signed({2'b00, e}) - 10'(BIAS);
        mant = {1'b1, f};
      end
      default: begin
        cls = CLS_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/ieee754_unpacker.sv
// Unpacks an IEEE-754 single into sign/exponent/significand/class,
// renormalising subnormals one bit per cycle.
module ieee754_unpacker
  import ieee754_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic signed [OEXP_W-1:0] out_exp,
  output logic [MANT_W-1:0]        out_mant,
  output logic [2:0]               out_class
);

  state_e                   state_q, state_d;
  logic                     sign_q, sign_d;
  logic signed [OEXP_W-1:0] exp_q, exp_d;
  logic [MANT_W-1:0]        mant_q, mant_d;
  cls_e                     cls_q, cls_d;

  logic                     c_sign;
  logic signed [OEXP_W-1:0] c_exp;
  logic [MANT_W-1:0]        c_mant;
  cls_e                     c_cls;
  logic                     c_norm;

  ieee754_classify u_classify (
    .word      (in_data),
    .sign      (c_sign),
    .exp       (c_exp),
    .mant      (c_mant),
    .cls       (c_cls),
    .need_norm (c_norm)
  );

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    cls_d   = cls_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = c_sign;
          exp_d   = c_exp;
          mant_d  = c_mant;
          cls_d   = c_cls;
          state_d = c_norm ? ST_NORM : ST_DONE;
        end
      end
      ST_NORM: begin
        // Bit 22 becoming the hidden bit ends renormalisation.
        mant_d = {mant_q[MANT_W-2:0], 1'b0};
        exp_d  = exp_q - 10'sd1;
        if (mant_q[MANT_W-2]) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      cls_q   <= CLS_ZERO;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      cls_q   <= cls_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sign  = sign_q;
  assign out_exp   = exp_q;
  assign out_mant  = mant_q;
  assign out_class = cls_q;

endmodule

// File: tb/tb_ieee754_unpacker.sv
// Self-checking bench for ieee754_unpacker: directed vectors plus
// random words checked against an arithmetic reference model.
module tb_ieee754_unpacker;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic signed [9:0] out_exp;
  logic [23:0]       out_mant;
  logic [2:0]        out_class;

  int checks;
  int failures;

  ieee754_unpacker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_mant  (out_mant),
    .out_class (out_class)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reference: value-level decode of sign/exponent/fraction.
  task automatic model(input  logic [31:0] w,
                       output logic        s,
                       output int          ex,
                       output logic [23:0] m,
                       output logic [2:0]  c,
                       output int          lat);
    int e;
    int f;
    int p;
    int lz;
    e   = int'(w[30:23]);
    f   = int'(w[22:0]);
    s   = w[31];
    lat = 1;
    if (e == 0 && f == 0) begin
      c  = 3'd0;
      ex = 0;
      m  = 24'd0;
    end else if (e == 0) begin
      p = 0;
      for (int i = 0; i < 23; i++)
        if (((f >> i) & 1) == 1) p = i;
      lz  = 23 - p;
      c   = 3'd1;
      ex  = -126 - lz;
      m   = 24'(f << lz);
      lat = 1 + lz;
    end else if (e == 255) begin
      c  = (f == 0) ? 3'd3 : 3'd4;
      ex = 128;
      m  = 24'((1 << 23) + f);
    end else begin
      c  = 3'd2;
      ex = e - 127;
      m  = 24'((1 << 23) + f);
    end
  endtask

  task automatic run_word(input logic [31:0] w,
                          input int hold);
    logic        es;
    int          eex;
    logic [23:0] em;
    logic [2:0]  ec;
    int          lat;
    int          n;
    model(w, es, eex, em, ec, lat);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = w;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("sign", 32'(out_sign), 32'(es));
    check("exp", 32'($signed(out_exp)), 32'(eex));
    check("mant", 32'(out_mant), 32'(em));
    check("class", 32'(out_class), 32'(ec));
    // Offer a junk word while the result is stalled.
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_exp", 32'($signed(out_exp)), 32'(eex));
      check("hold_mant", 32'(out_mant), 32'(em));
      check("hold_class", 32'(out_class), 32'(ec));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          r;
    int          seen;
    logic        rs;
    logic [7:0]  re;
    logic [22:0] rf;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_sign", 32'(out_sign), 32'd0);
    check("rst_exp", 32'($signed(out_exp)), 32'd0);
    check("rst_mant", 32'(out_mant), 32'd0);
    check("rst_class", 32'(out_class), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_word(32'h41F0_0000, 0);
    run_word(32'h0000_0001, 0);
    run_word(32'hFF80_0000, 0);
    run_word(32'h7FC0_0000, 0);
    run_word(32'h8000_0000, 0);
    run_word(32'h4120_0000, 5);
    run_word(32'h007F_FFFF, 1);
    run_word(32'h0080_0000, 0);
    run_word(32'h7F7F_FFFF, 0);

    for (int t = 0; t < 30; t++) begin
      r  = $urandom_range(0, 4);
      rs = 1'($urandom);
      rf = 23'($urandom);
      re = 8'($urandom_range(1, 254));
      unique case (r)
        0: in_data = {rs, 31'd0};
        1: in_data = {rs, 8'd0, (rf == 0) ? 23'd1 : rf};
        2: in_data = {rs, re, rf};
        3: in_data = {rs, 8'hFF, 23'd0};
        default: in_data = {rs, 8'hFF, (rf == 0) ? 23'd5 : rf};
      endcase
      run_word(in_data, $urandom_range(0, 3));
    end

    // Abort a subnormal mid-renormalisation.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_0100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("norm_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd1);
    check("abort_mant", 32'(out_mant), 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("abort_no_result", 32'(seen), 32'd0);

    run_word(32'h41F0_0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
